// File: rtl/lsu_wb_pipe.sv
// lsu_wb_pipe: LSU-to-writeback stage with 2-entry skid buffer, flush, x0 suppression and retire counter
module lsu_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lsu_valid_i,
    output logic               lsu_ready_o,
    input  logic [DATA_W-1:0]  lsu_reg_wdata_i,
    input  logic               lsu_wr_reg_en_i,
    input  logic [RADDR_W-1:0] lsu_wr_reg_addr_i,
    input  logic [DATA_W-1:0]  lsu_pc_i,
    input  logic [DATA_W-1:0]  lsu_inst_i,
    input  logic               flush_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [DATA_W-1:0]  wb_reg_wdata_o,
    output logic               wb_wr_reg_en_o,
    output logic [RADDR_W-1:0] wb_wr_reg_addr_o,
    output logic [DATA_W-1:0]  wb_pc_o,
    output logic [DATA_W-1:0]  wb_inst_o,
    output logic [CNT_W-1:0]   retired_cnt_o
);
    localparam int PW = 3 * DATA_W + RADDR_W + 1;

    logic [PW-1:0]    in_pl, main_q, main_d, skid_q, skid_d;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire, main_en;

    assign in_pl    = {lsu_reg_wdata_i, lsu_wr_reg_en_i, lsu_wr_reg_addr_i, lsu_pc_i, lsu_inst_i};
    assign in_fire  = lsu_valid_i & ~skid_v_q;
    assign out_fire = main_v_q & wb_ready_i;

    // Next state: flush wins; skid drains into main before any new beat is taken
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (out_fire) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (in_fire && (!main_v_q || out_fire)) begin
            main_d   = in_pl;
            main_v_d = 1'b1;
        end else if (in_fire) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
        end else if (out_fire) begin
            main_v_d = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(out_fire);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign {wb_reg_wdata_o, main_en, wb_wr_reg_addr_o, wb_pc_o, wb_inst_o} = main_q;
    assign wb_valid_o     = main_v_q;
    assign wb_wr_reg_en_o = main_en & main_v_q & (|wb_wr_reg_addr_o);
    assign lsu_ready_o    = ~skid_v_q;
    assign retired_cnt_o  = cnt_q;
endmodule

// File: tb/tb_lsu_wb_pipe.sv
// tb_lsu_wb_pipe: scoreboard bench for lsu_wb_pipe
module tb_lsu_wb_pipe;
    typedef struct packed {
        logic [31:0] wdata;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [31:0] lsu_reg_wdata_i = '0;
    logic        lsu_wr_reg_en_i = 1'b0;
    logic [4:0]  lsu_wr_reg_addr_i = '0;
    logic [31:0] lsu_pc_i = '0;
    logic [31:0] lsu_inst_i = '0;
    logic        flush_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_reg_wdata_o;
    logic        wb_wr_reg_en_o;
    logic [4:0]  wb_wr_reg_addr_o;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_inst_o;
    logic [63:0] retired_cnt_o;

    beat_t       sb[$];
    logic [63:0] exp_cnt = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    lsu_wb_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_reg_wdata_i(lsu_reg_wdata_i), .lsu_wr_reg_en_i(lsu_wr_reg_en_i),
        .lsu_wr_reg_addr_i(lsu_wr_reg_addr_i), .lsu_pc_i(lsu_pc_i), .lsu_inst_i(lsu_inst_i),
        .flush_i(flush_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_reg_wdata_o(wb_reg_wdata_o), .wb_wr_reg_en_o(wb_wr_reg_en_o),
        .wb_wr_reg_addr_o(wb_wr_reg_addr_o), .wb_pc_o(wb_pc_o), .wb_inst_o(wb_inst_o),
        .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] pc, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic en);
        lsu_valid_i       = v;
        lsu_pc_i          = pc;
        lsu_wr_reg_addr_i = addr;
        lsu_reg_wdata_i   = wdata;
        lsu_wr_reg_en_i   = en;
        lsu_inst_i        = $urandom;
    endtask

    // Scoreboard: sb holds the beats the stage should currently contain, oldest first
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt = '0;
            chk("rst_valid", wb_valid_o, 0);
            chk("rst_ready", lsu_ready_o, 1);
            chk("rst_wen", wb_wr_reg_en_o, 0);
            chk("rst_cnt", retired_cnt_o, 0);
            chk("rst_data", {wb_reg_wdata_o, wb_wr_reg_addr_o, wb_pc_o, wb_inst_o}, 0);
        end else begin
            automatic logic  acc = lsu_valid_i && sb.size() < 2;
            automatic beat_t nb = '{lsu_reg_wdata_i, lsu_wr_reg_en_i, lsu_wr_reg_addr_i, lsu_pc_i, lsu_inst_i};
            chk("ready", lsu_ready_o, sb.size() < 2);
            chk("valid", wb_valid_o, sb.size() != 0);
            chk("cnt", retired_cnt_o, exp_cnt);
            if (sb.size() != 0) begin
                chk("payload", {wb_reg_wdata_o, wb_wr_reg_addr_o, wb_pc_o, wb_inst_o},
                    {sb[0].wdata, sb[0].addr, sb[0].pc, sb[0].inst});
                chk("wen", wb_wr_reg_en_o, sb[0].en && sb[0].addr != 0);
                if (wb_ready_i) begin
                    void'(sb.pop_front());
                    exp_cnt++;
                end
            end else begin
                chk("wen_idle", wb_wr_reg_en_o, 0);
            end
            if (flush_i) sb.delete();
            else if (acc) sb.push_back(nb);
        end
    end

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        // single beat
        wb_ready_i = 1'b1;
        beat(1, 32'h100, 5, 32'hDEADBEEF, 1);
        cyc();
        beat(0, 0, 0, 0, 0);
        chk("s1_valid", wb_valid_o, 1);
        chk("s1_pc", wb_pc_o, 32'h100);
        chk("s1_addr", wb_wr_reg_addr_o, 5);
        chk("s1_wdata", wb_reg_wdata_o, 32'hDEADBEEF);
        chk("s1_wen", wb_wr_reg_en_o, 1);
        cyc();
        chk("s1_idle", wb_valid_o, 0);
        chk("s1_cnt", retired_cnt_o, 1);
        // backpressure
        wb_ready_i = 1'b0;
        beat(1, 32'h100, 1, 32'h11, 1);
        cyc();
        beat(1, 32'h104, 2, 32'h22, 1);
        cyc();
        beat(0, 0, 0, 0, 0);
        chk("s2_full", lsu_ready_o, 0);
        chk("s2_pc", wb_pc_o, 32'h100);
        cyc();
        chk("s2_hold", wb_pc_o, 32'h100);
        wb_ready_i = 1'b1;
        cyc();
        chk("s2_pc2", wb_pc_o, 32'h104);
        chk("s2_ready", lsu_ready_o, 1);
        cyc();
        chk("s2_cnt", retired_cnt_o, 3);
        // streaming
        for (int i = 0; i < 16; i++) begin
            beat(1, 32'(i * 4), 5'(i + 1), $urandom, 1);
            cyc();
        end
        beat(0, 0, 0, 0, 0);
        cyc();
        chk("s3_cnt", retired_cnt_o, 19);
        // flush while full
        wb_ready_i = 1'b0;
        beat(1, 32'h300, 3, 32'h33, 1);
        cyc();
        beat(1, 32'h304, 4, 32'h44, 1);
        cyc();
        beat(1, 32'h200, 6, 32'h66, 1);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        beat(0, 0, 0, 0, 0);
        chk("s4_valid", wb_valid_o, 0);
        chk("s4_ready", lsu_ready_o, 1);
        chk("s4_cnt", retired_cnt_o, 19);
        wb_ready_i = 1'b1;
        cyc();
        chk("s4_drop", wb_valid_o, 0);
        // x0 write
        beat(1, 32'h400, 0, 32'h5, 1);
        cyc();
        beat(0, 0, 0, 0, 0);
        chk("s5_valid", wb_valid_o, 1);
        chk("s5_wen", wb_wr_reg_en_o, 0);
        chk("s5_wdata", wb_reg_wdata_o, 32'h5);
        cyc();
        chk("s5_cnt", retired_cnt_o, 20);
        // reset mid-transfer
        wb_ready_i = 1'b0;
        beat(1, 32'h500, 7, 32'h77, 1);
        cyc();
        beat(1, 32'h504, 8, 32'h88, 1);
        cyc();
        beat(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("r_valid", wb_valid_o, 0);
        chk("r_ready", lsu_ready_o, 1);
        chk("r_cnt", retired_cnt_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("r_after", wb_valid_o, 0);
        // random handshake against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            beat($urandom_range(0, 9) < 7, $urandom, 5'($urandom), $urandom, 1'($urandom));
            wb_ready_i = $urandom_range(0, 9) < 6;
            flush_i    = $urandom_range(0, 99) == 0;
            cyc();
        end
        beat(0, 0, 0, 0, 0);
        flush_i    = 1'b0;
        wb_ready_i = 1'b1;
        repeat (4) cyc();
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
